// File: rtl/fma_align_pipe.sv
// Purpose : FMA addend aligner. It computes the exponent difference between
//           A and B*C, right-shifts A's mantissa into a (3*(MANT+1)+2)-bit
//           window, and derives the sticky bit. The Wallace partials travel
//           alongside the aligned addend.
// Latency : 2 register stages (S1 input register, S2 output register).
//           Throughput is 1 op/cycle.
// Backpr. : valid/ready handshake. The output holds while out_valid_o &
//           ~out_ready_i. in_ready_o drops only when both stages are full and
//           the output is stalled. flush_i drops both stages.
// Ports   : clk_i/rst_i (sync, active-high), flush_i;
//           in_valid_i/in_ready_o with the operand signs, exponents, A mantissa
//           and Wallace partials;
//           out_valid_o/out_ready_i with the aligned addend, exponent, sign,
//           move-sign, halt, sticky and Wallace partials;
//           halt_cnt_o is a saturating count of halted operations.
module fma_align_pipe #(
   parameter int PARM_EXP  = 8,
   parameter int PARM_MANT = 23,
   parameter int PARM_BIAS = 127
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic                       A_sign_i,
   input  logic                       B_sign_i,
   input  logic                       C_sign_i,
   input  logic                       Sub_Sign_i,
   input  logic [PARM_EXP-1:0]        A_Exp_i,
   input  logic [PARM_EXP-1:0]        B_Exp_i,
   input  logic [PARM_EXP-1:0]        C_Exp_i,
   input  logic [PARM_MANT:0]         A_Mant_i,
   input  logic [2*PARM_MANT+2:0]     Wallace_sum_i,
   input  logic [2*PARM_MANT+2:0]     Wallace_carry_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [3*PARM_MANT+5:0]     A_Mant_aligned_o,
   output logic [PARM_EXP+1:0]        Exp_aligned_o,
   output logic                       Sign_aligned_o,
   output logic                       Exp_mv_sign_o,
   output logic                       Mv_halt_o,
   output logic                       Mant_sticky_o,
   output logic [2*PARM_MANT+2:0]     Wallace_sum_aligned_o,
   output logic [2*PARM_MANT+2:0]     Wallace_carry_aligned_o,
   output logic [15:0]                halt_cnt_o
);

   // W is the alignment window width and D is the binary-point distance
   // between the addend and the product inside that window.
   localparam int W      = 3 * PARM_MANT + 5;
   localparam int D      = PARM_MANT + 4;
   localparam int EW     = PARM_EXP + 2;
   localparam int M1     = PARM_MANT + 1;
   localparam int WW     = 2 * PARM_MANT + 3;
   localparam int SGN_SH = 2 * PARM_MANT + 4;

   localparam logic [EW-1:0] D_E    = D[EW-1:0];
   localparam logic [EW-1:0] BIAS_E = PARM_BIAS[EW-1:0];
   localparam logic [31:0]   W_U    = W[31:0];

   typedef struct packed {
      logic                a_sign;
      logic                b_sign;
      logic                c_sign;
      logic                sub;
      logic [PARM_EXP-1:0] a_exp;
      logic [PARM_EXP-1:0] b_exp;
      logic [PARM_EXP-1:0] c_exp;
      logic [M1-1:0]       a_mant;
      logic [WW-1:0]       wsum;
      logic [WW-1:0]       wcarry;
   } op_t;

   typedef struct packed {
      logic [W:0]    a_mant_al;
      logic [EW-1:0] exp_al;
      logic          sign_al;
      logic          mv_sign;
      logic          mv_halt;
      logic          sticky;
      logic [WW-1:0] wsum;
      logic [WW-1:0] wcarry;
   } res_t;

   // ---------------------------------------------------------------- state
   logic        s1_valid_q, s1_valid_d;
   op_t         s1_op_q, s1_op_d;
   logic        out_valid_q, out_valid_d;
   res_t        res_q, res_d;
   logic [15:0] halt_cnt_q, halt_cnt_d;

   // ------------------------------------------------------------ handshake
   logic s2_adv;
   logic s1_adv;
   logic in_fire;
   op_t  in_op;

   always_comb begin
      s2_adv  = ~out_valid_q | out_ready_i;
      // A flushed S1 operation never reaches S2, so it is neither
      // forwarded nor counted.
      s1_adv  = s1_valid_q & s2_adv & ~flush_i;
      in_fire = in_valid_i & (~s1_valid_q | s2_adv) & ~flush_i;
   end

   assign in_ready_o = ~s1_valid_q | s2_adv;

   always_comb begin
      in_op.a_sign = A_sign_i;
      in_op.b_sign = B_sign_i;
      in_op.c_sign = C_sign_i;
      in_op.sub    = Sub_Sign_i;
      in_op.a_exp  = A_Exp_i;
      in_op.b_exp  = B_Exp_i;
      in_op.c_exp  = C_Exp_i;
      in_op.a_mant = A_Mant_i;
      in_op.wsum   = Wallace_sum_i;
      in_op.wcarry = Wallace_carry_i;
   end

   // ------------------------------------------------ S1 exponent datapath
   logic [EW-1:0]   a_e, b_e, c_e;
   logic [EW-1:0]   prod_e;
   logic [EW-1:0]   mv;
   logic            mv_sgn;
   logic            mv_halt;
   logic [31:0]     mv_mag;
   logic [EW-1:0]   expo;
   logic [EW-1:0]   sh;
   logic [W+M1-1:0] shifted;
   logic [W-1:0]    al;
   logic [M1-1:0]   drop;
   logic [W:0]      sgn_mant;
   res_t            res_new;

   always_comb begin
      a_e    = {2'b00, s1_op_q.a_exp};
      b_e    = {2'b00, s1_op_q.b_exp};
      c_e    = {2'b00, s1_op_q.c_exp};
      prod_e = b_e + c_e - BIAS_E;
      // All exponent arithmetic wraps modulo 2^EW. The top bit marks an
      // addend that is larger than the product, so no right shift is needed.
      mv     = D_E - a_e + b_e + c_e - BIAS_E;
      mv_sgn = mv[EW-1];
      mv_mag = {{(31-PARM_EXP){1'b0}}, mv[PARM_EXP:0]};
      // A shift of W or more pushes the whole addend below the window.
      mv_halt = ~mv_sgn & (mv_mag >= W_U);
      expo    = mv_sgn ? a_e : prod_e + D_E;
   end

   // ----------------------------------------------------- S2 shift / select
   always_comb begin
      sh       = (mv_halt | mv_sgn) ? '0 : mv;
      shifted  = {s1_op_q.a_mant, {W{1'b0}}} >> sh;
      al       = shifted[W+M1-1:M1];
      drop     = shifted[M1-1:0];
      sgn_mant = {{(W+1-M1){1'b0}}, s1_op_q.a_mant} << SGN_SH;

      res_new.exp_al  = expo;
      res_new.mv_sign = mv_sgn;
      res_new.mv_halt = mv_halt;
      if (mv_sgn) begin
         res_new.a_mant_al = sgn_mant;
         res_new.sign_al   = s1_op_q.a_sign;
         res_new.wsum      = '0;
         res_new.wcarry    = '0;
         res_new.sticky    = 1'b0;
      end else if (!mv_halt) begin
         // Subtraction is a one's complement here. The +1 is applied
         // downstream, and the sticky bit is unaffected because the negation
         // of a non-zero value is still non-zero.
         res_new.a_mant_al = {s1_op_q.sub, al ^ {W{s1_op_q.sub}}};
         res_new.sign_al   = s1_op_q.b_sign ^ s1_op_q.c_sign;
         res_new.wsum      = s1_op_q.wsum;
         res_new.wcarry    = s1_op_q.wcarry;
         res_new.sticky    = |drop;
      end else begin
         res_new.a_mant_al = '0;
         res_new.sign_al   = s1_op_q.b_sign ^ s1_op_q.c_sign;
         res_new.wsum      = s1_op_q.wsum;
         res_new.wcarry    = s1_op_q.wcarry;
         res_new.sticky    = |s1_op_q.a_mant;
      end
   end

   // ------------------------------------------------------- next state
   always_comb begin
      s1_op_d = in_fire ? in_op : s1_op_q;

      if (flush_i)
         s1_valid_d = 1'b0;
      else if (in_fire)
         s1_valid_d = 1'b1;
      else if (s1_adv)
         s1_valid_d = 1'b0;
      else
         s1_valid_d = s1_valid_q;

      if (flush_i)
         out_valid_d = 1'b0;
      else if (s1_adv)
         out_valid_d = 1'b1;
      else if (out_ready_i)
         out_valid_d = 1'b0;
      else
         out_valid_d = out_valid_q;

      // The output register loads only on an S1 advance, so the output data
      // is frozen for the whole time the output is stalled.
      res_d = s1_adv ? res_new : res_q;

      if (s1_adv && mv_halt && (halt_cnt_q != 16'hFFFF))
         halt_cnt_d = halt_cnt_q + 16'd1;
      else
         halt_cnt_d = halt_cnt_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid_q  <= 1'b0;
         s1_op_q     <= '0;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         halt_cnt_q  <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_op_q     <= s1_op_d;
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         halt_cnt_q  <= halt_cnt_d;
      end
   end

   // --------------------------------------------------------------- outputs
   assign out_valid_o             = out_valid_q;
   assign A_Mant_aligned_o        = res_q.a_mant_al;
   assign Exp_aligned_o           = res_q.exp_al;
   assign Sign_aligned_o          = res_q.sign_al;
   assign Exp_mv_sign_o           = res_q.mv_sign;
   assign Mv_halt_o               = res_q.mv_halt;
   assign Mant_sticky_o           = res_q.sticky;
   assign Wallace_sum_aligned_o   = res_q.wsum;
   assign Wallace_carry_aligned_o = res_q.wcarry;
   assign halt_cnt_o              = halt_cnt_q;

endmodule

// File: tb/tb_fma_align_pipe.sv
// Bench for fma_align_pipe at default parameters: directed literal cases
// followed by randomized traffic checked each cycle against a behavioural model.
module tb_fma_align_pipe;

   localparam int P_EXP  = 8;
   localparam int P_MANT = 23;
   localparam int P_BIAS = 127;
   localparam int W      = 3 * P_MANT + 5;
   localparam int D      = P_MANT + 4;
   localparam int M1     = P_MANT + 1;
   localparam int EW     = P_EXP + 2;
   localparam int WW     = 2 * P_MANT + 3;

   typedef struct packed {
      logic          as, bs, cs, sub;
      logic [P_EXP-1:0] ae, be, ce;
      logic [M1-1:0] am;
      logic [WW-1:0] ws, wc;
   } op_t;

   typedef struct packed {
      logic [W:0]    a_al;
      logic [EW-1:0] expo;
      logic          sign, mvs, halt, sticky;
      logic [WW-1:0] ws, wc;
   } res_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   op_t  cur = '0;

   logic          in_ready, out_valid;
   logic [W:0]    a_al;
   logic [EW-1:0] expo;
   logic          sign_al, mvs, halt, sticky;
   logic [WW-1:0] ws_o, wc_o;
   logic [15:0]   halt_cnt;
   res_t          dut_res;

   assign dut_res = '{a_al: a_al, expo: expo, sign: sign_al, mvs: mvs,
                      halt: halt, sticky: sticky, ws: ws_o, wc: wc_o};

   fma_align_pipe #(.PARM_EXP(P_EXP), .PARM_MANT(P_MANT), .PARM_BIAS(P_BIAS)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .A_sign_i(cur.as), .B_sign_i(cur.bs), .C_sign_i(cur.cs), .Sub_Sign_i(cur.sub),
      .A_Exp_i(cur.ae), .B_Exp_i(cur.be), .C_Exp_i(cur.ce), .A_Mant_i(cur.am),
      .Wallace_sum_i(cur.ws), .Wallace_carry_i(cur.wc),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .A_Mant_aligned_o(a_al), .Exp_aligned_o(expo), .Sign_aligned_o(sign_al),
      .Exp_mv_sign_o(mvs), .Mv_halt_o(halt), .Mant_sticky_o(sticky),
      .Wallace_sum_aligned_o(ws_o), .Wallace_carry_aligned_o(wc_o),
      .halt_cnt_o(halt_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------------------------------------------- reference model
   function automatic res_t ref_model(input op_t o);
      res_t r;
      int ae, be, ce, raw, mv, mag;
      bit sgn, hlt;
      logic [255:0] v, one, mask_w, mask_m, al, drop;
      ae = o.ae; be = o.be; ce = o.ce;
      raw = D - ae + be + ce - P_BIAS;
      mv  = raw & ((1 << EW) - 1);
      sgn = (mv >= (1 << (EW - 1)));
      mag = mv % (1 << (EW - 1));
      hlt = !sgn && (mag >= W);
      one = 256'd1;
      mask_w = (one << W) - one;
      mask_m = (one << M1) - one;
      r = '0;
      r.mvs  = sgn;
      r.halt = hlt;
      r.expo = sgn ? EW'(ae) : EW'((be + ce - P_BIAS + D) & ((1 << EW) - 1));
      if (sgn) begin
         v = '0; v[M1-1:0] = o.am;
         v = v << (2 * P_MANT + 4);
         r.a_al = v[W:0];
         r.sign = o.as;
      end else if (!hlt) begin
         v = '0; v[M1-1:0] = o.am;
         v = (v << W) >> mv;
         al   = (v >> M1) & mask_w;
         drop = v & mask_m;
         r.a_al   = {o.sub, (o.sub ? ~al[W-1:0] : al[W-1:0])};
         r.sign   = o.bs ^ o.cs;
         r.ws     = o.ws;
         r.wc     = o.wc;
         r.sticky = (drop != 0);
      end else begin
         r.sign   = o.bs ^ o.cs;
         r.ws     = o.ws;
         r.wc     = o.wc;
         r.sticky = (o.am != 0);
      end
      return r;
   endfunction

   // Transaction-level pipeline occupancy: one slot in S1, one at the output.
   bit   m_s1_vld = 0, m_out_vld = 0;
   op_t  m_s1_op = '0;
   res_t m_out = '0;
   int   m_cnt = 0;

   initial forever begin
      bit s2a, inr;
      @(posedge clk);
      if (rst) begin
         m_s1_vld = 0; m_out_vld = 0; m_out = '0; m_cnt = 0;
      end else if (flush) begin
         m_s1_vld = 0; m_out_vld = 0;
      end else begin
         s2a = !m_out_vld || out_ready;
         inr = !m_s1_vld || s2a;
         if (m_s1_vld && s2a) begin
            m_out = ref_model(m_s1_op);
            m_out_vld = 1;
            m_s1_vld = 0;
            if (m_out.halt && m_cnt < 65535) m_cnt++;
         end else if (s2a) begin
            m_out_vld = 0;
         end
         if (in_valid && inr) begin
            m_s1_op = cur;
            m_s1_vld = 1;
         end
      end
   end

   // Single compare process, away from the active edge.
   initial forever begin
      @(negedge clk);
      chk("out_valid", 256'(out_valid), 256'(m_out_vld));
      chk("in_ready", 256'(in_ready), 256'(!m_s1_vld || !m_out_vld || out_ready));
      chk("halt_cnt", 256'(halt_cnt), 256'(m_cnt));
      if (out_valid && m_out_vld)
         chk("out_data", 256'(dut_res), 256'(m_out));
   end

   // ------------------------------------------------------------ stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic op_t mk(input logic as_, bs_, cs_, sub_, input int ae_, be_, ce_,
                              input logic [M1-1:0] am_);
      op_t o;
      o.as = as_; o.bs = bs_; o.cs = cs_; o.sub = sub_;
      o.ae = P_EXP'(ae_); o.be = P_EXP'(be_); o.ce = P_EXP'(ce_);
      o.am = am_;
      o.ws = 49'h1_2345_6789_ABCD;
      o.wc = 49'h0_FEDC_BA98_7654;
      return o;
   endfunction

   function automatic op_t rnd_op();
      op_t o;
      int  pick;
      o.as = 1'($urandom); o.bs = 1'($urandom); o.cs = 1'($urandom); o.sub = 1'($urandom);
      o.ae = P_EXP'($urandom); o.be = P_EXP'($urandom); o.ce = P_EXP'($urandom);
      pick = $urandom_range(0, 7);
      if (pick == 0) begin
         // Around the shift boundaries: mv = 73, 74, 0, -1.
         o.be = 8'd127; o.ce = 8'd127;
         case ($urandom_range(0, 3))
            0: o.ae = 8'd80;
            1: o.ae = 8'd81;
            2: o.ae = 8'd154;
            default: o.ae = 8'd155;
         endcase
      end
      o.am = {1'b1, 23'($urandom)};
      if ($urandom_range(0, 15) == 0) o.am = M1'($urandom_range(0, 3));
      o.ws = {17'($urandom), 32'($urandom)};
      o.wc = {17'($urandom), 32'($urandom)};
      return o;
   endfunction

   // Sends one op with an open output and waits for its result.
   task automatic send1(input op_t o, input string nm);
      int edges;
      cur = o; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      edges = 1;
      while (!out_valid && edges < 10) begin
         tick();
         edges++;
      end
      chk({nm, "_latency"}, 256'(edges), 256'(2));
   endtask

   initial begin
      logic [W:0] e;
      int n_out;

      repeat (3) tick();
      rst = 1'b0;
      chk("rst_out_valid", 256'(out_valid), 256'(0));
      chk("rst_in_ready", 256'(in_ready), 256'(1));
      chk("rst_halt_cnt", 256'(halt_cnt), 256'(0));
      chk("rst_data", 256'(dut_res), 256'(0));

      // Halt: mv = 299.
      send1(mk(0, 1, 0, 0, 1, 200, 200, 24'h800001), "halt");
      chk("halt_flag", 256'(halt), 256'(1));
      chk("halt_al", 256'(a_al), 256'(0));
      chk("halt_sticky", 256'(sticky), 256'(1));
      chk("halt_exp", 256'(expo), 256'(300));
      chk("halt_cnt1", 256'(halt_cnt), 256'(1));

      // Nominal: mv = 27.
      send1(mk(0, 0, 0, 0, 127, 127, 127, 24'h800000), "nom");
      e = '0; e[46] = 1'b1;
      chk("nom_al", 256'(a_al), 256'(e));
      chk("nom_exp", 256'(expo), 256'(154));
      chk("nom_sticky", 256'(sticky), 256'(0));
      chk("nom_mvs_halt", 256'({mvs, halt}), 256'(0));
      chk("nom_ws", 256'(ws_o), 256'(49'h1_2345_6789_ABCD));

      // Negative shift: addend dominates.
      send1(mk(1, 0, 0, 0, 200, 127, 127, 24'hC00000), "neg");
      e = '0; e[23:0] = 24'hC00000; e = e << 50;
      chk("neg_mvs", 256'(mvs), 256'(1));
      chk("neg_exp", 256'(expo), 256'(200));
      chk("neg_al", 256'(a_al), 256'(e));
      chk("neg_wallace", 256'({ws_o, wc_o}), 256'(0));
      chk("neg_sign", 256'(sign_al), 256'(1));

      // Subtract with sticky: mv = 54.
      send1(mk(0, 1, 1, 1, 100, 127, 127, 24'h800003), "sub");
      e = '1; e[19] = 1'b0;
      chk("sub_al", 256'(a_al), 256'(e));
      chk("sub_sticky", 256'(sticky), 256'(1));

      // Largest non-halting shift (mv = 73) and the first halting one (mv = 74).
      send1(mk(0, 0, 0, 0, 81, 127, 127, 24'h800000), "mv73");
      chk("mv73_al", 256'(a_al), 256'(1));
      chk("mv73_halt", 256'(halt), 256'(0));
      send1(mk(0, 0, 0, 0, 80, 127, 127, 24'h800000), "mv74");
      chk("mv74_halt", 256'(halt), 256'(1));
      chk("mv74_sticky", 256'(sticky), 256'(1));
      tick();

      // Backpressure: two accepted, third held.
      out_ready = 1'b0;
      in_valid = 1'b1;
      cur = mk(0, 0, 0, 0, 127, 127, 127, 24'h800001); tick();
      cur = mk(0, 0, 0, 0, 127, 127, 127, 24'h800002); tick();
      cur = mk(0, 0, 0, 0, 127, 127, 127, 24'h800004);
      repeat (2) tick();
      chk("bp_in_ready", 256'(in_ready), 256'(0));
      chk("bp_out_valid", 256'(out_valid), 256'(1));
      chk("bp_hold_op1", 256'(a_al), 256'(ref_model(mk(0, 0, 0, 0, 127, 127, 127, 24'h800001)).a_al));
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      n_out = 1;
      for (int k = 0; k < 5; k++) begin
         if (out_valid) n_out++;
         tick();
      end
      chk("bp_drain_count", 256'(n_out), 256'(3));

      // Flush with both stages full.
      out_ready = 1'b0; in_valid = 1'b1;
      cur = rnd_op(); tick();
      cur = rnd_op(); tick();
      flush = 1'b1; cur = rnd_op();
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_out_valid", 256'(out_valid), 256'(0));
      chk("flush_in_ready", 256'(in_ready), 256'(1));

      // Reset with both stages full.
      in_valid = 1'b1;
      cur = mk(0, 0, 0, 0, 1, 200, 200, 24'h800000); tick();
      cur = mk(0, 0, 0, 0, 1, 200, 200, 24'h800000); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      chk("midrst_out_valid", 256'(out_valid), 256'(0));
      chk("midrst_halt_cnt", 256'(halt_cnt), 256'(0));
      chk("midrst_data", 256'(dut_res), 256'(0));

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         cur       = rnd_op();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 63) == 0);
         rst       = ($urandom_range(0, 999) == 0);
         tick();
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
